// File: rtl/reg_access_pkg.sv
// Shared types and constants for the register-access sequencer.
package reg_access_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_LSB = 11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        OPND,
        WB,
        WR
    } state_t;

endpackage

// File: rtl/reg_field_dec.sv
// Extracts rs/rt register indices and the writeback destination from a MIPS word.
module reg_field_dec
    import reg_access_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [31:0]       instr,
    input  logic              reg_dst,
    output logic [ADDR_W-1:0] rs,
    output logic [ADDR_W-1:0] rt,
    output logic [ADDR_W-1:0] dest
);

    logic unused_instr;

    always_comb begin
        rs           = instr[RS_LSB +: ADDR_W];
        rt           = instr[RT_LSB +: ADDR_W];
        dest         = reg_dst ? instr[RD_LSB +: ADDR_W] : instr[RT_LSB +: ADDR_W];
        unused_instr = ^instr;
    end

endmodule

// File: rtl/reg_access_seq.sv
// Register-file access sequencer: decode, read, capture, hand off operands, write back.
// Optional `REG_ZERO_GUARD_EN forces operands from register index 0 to zero.
module reg_access_seq
    import reg_access_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              reg_dst,
    output logic              opnd_valid,
    input  logic              opnd_ready,
    output logic [DATA_W-1:0] opnd_a,
    output logic [DATA_W-1:0] opnd_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic              wb_en,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] readRegA,
    output logic [ADDR_W-1:0] readRegB,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              RegRead,
    output logic              RegWrite,
    input  logic [DATA_W-1:0] regA,
    input  logic [DATA_W-1:0] regB
);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] dec_rs, dec_rt, dec_dest;
    logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    logic [DATA_W-1:0] opnd_a_q, opnd_a_d, opnd_b_q, opnd_b_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              instr_acc, wb_acc;

    reg_field_dec #(.ADDR_W(ADDR_W)) u_dec (
        .instr   (instr),
        .reg_dst (reg_dst),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .dest    (dec_dest)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (instr_valid) state_d = RD;
            RD:   state_d = CAP;
            CAP:  state_d = OPND;
            OPND: if (opnd_ready) state_d = WB;
            WB: begin
                if (wb_valid) begin
                    state_d = (wb_en && (dest_q != '0)) ? WR : IDLE;
                end
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset parks the state in IDLE, so ready is additionally gated until release.
    always_comb begin
        instr_ready = (state_q == IDLE) && rst_n;
        RegRead     = (state_q == RD);
        RegWrite    = (state_q == WR);
        opnd_valid  = (state_q == OPND);
        wb_ready    = (state_q == WB);
        readRegA    = rs_q;
        readRegB    = rt_q;
        writeReg    = dest_q;
        writeData   = wdata_q;
        opnd_a      = opnd_a_q;
        opnd_b      = opnd_b_q;
    end

    assign instr_acc = instr_valid && instr_ready;
    assign wb_acc    = wb_valid && wb_ready;

    always_comb begin
        rs_d     = rs_q;
        rt_d     = rt_q;
        dest_d   = dest_q;
        opnd_a_d = opnd_a_q;
        opnd_b_d = opnd_b_q;
        wdata_d  = wdata_q;
        if (instr_acc) begin
            rs_d   = dec_rs;
            rt_d   = dec_rt;
            dest_d = dec_dest;
        end
        if (state_q == CAP) begin
`ifdef REG_ZERO_GUARD_EN
            opnd_a_d = (rs_q == '0) ? '0 : regA;
            opnd_b_d = (rt_q == '0) ? '0 : regB;
`else
            opnd_a_d = regA;
            opnd_b_d = regB;
`endif
        end
        if (wb_acc) begin
            wdata_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q     <= '0;
            rt_q     <= '0;
            dest_q   <= '0;
            opnd_a_q <= '0;
            opnd_b_q <= '0;
            wdata_q  <= '0;
        end else begin
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            dest_q   <= dest_d;
            opnd_a_q <= opnd_a_d;
            opnd_b_q <= opnd_b_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_reg_access_seq.sv
// Scoreboard bench for reg_access_seq with a registered-read register-file model.
module tb_reg_access_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } opnd_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        instr_valid = 0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic        reg_dst = 0;
    logic        opnd_valid;
    logic        opnd_ready = 0;
    logic [31:0] opnd_a, opnd_b;
    logic        wb_valid = 0;
    logic        wb_ready;
    logic        wb_en = 0;
    logic [31:0] wb_data = '0;
    logic [4:0]  readRegA, readRegB, writeReg;
    logic [31:0] writeData;
    logic        RegRead, RegWrite;
    logic [31:0] regA, regB;

    logic [31:0] rf [32];
    logic [31:0] exp_rf [32];
    logic        rf_init = 0;
    logic        rd_pend = 0;
    logic [4:0]  ra_q = '0, rb_q = '0;

    opnd_t opnd_q[$];
    wr_t   wr_q[$];
    wr_t   mon_ew;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_wr = 0;
    int    n_exp_wr = 0;
    logic  prev_wr = 0;

    reg_access_seq #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .reg_dst     (reg_dst),
        .opnd_valid  (opnd_valid),
        .opnd_ready  (opnd_ready),
        .opnd_a      (opnd_a),
        .opnd_b      (opnd_b),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_en       (wb_en),
        .wb_data     (wb_data),
        .readRegA    (readRegA),
        .readRegB    (readRegB),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .RegRead     (RegRead),
        .RegWrite    (RegWrite),
        .regA        (regA),
        .regB        (regB)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int unsigned i);
        case (i)
            0:       return 32'h0000_0055;
            3:       return 32'h0000_0011;
            7:       return 32'h0000_0022;
            default: return 32'hA500_0000 | i;
        endcase
    endfunction

    // Register file answers one cycle after RegRead; other cycles return junk.
    always @(posedge clk) begin
        rd_pend <= RegRead;
        ra_q    <= readRegA;
        rb_q    <= readRegB;
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (RegWrite) begin
            rf[writeReg] <= writeData;
        end
    end

    assign regA = rd_pend ? rf[ra_q] : 32'hBADC_0DE0;
    assign regB = rd_pend ? rf[rb_q] : 32'hBADC_0DE1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_operand(input logic [4:0] idx);
`ifdef REG_ZERO_GUARD_EN
        if (idx == 5'd0) return 32'h0;
`endif
        return exp_rf[idx];
    endfunction

    always @(negedge clk) begin
        chk("rd_wr_excl", RegRead & RegWrite, 0);
        if (RegWrite) begin
            if (wr_q.size() == 0) begin
                chk("unexp_wr", RegWrite, 0);
            end else begin
                mon_ew = wr_q.pop_front();
                chk("wr_addr", writeReg, mon_ew.a);
                chk("wr_data", writeData, mon_ew.d);
                n_wr++;
            end
        end
    end

    task automatic do_reset();
        rst_n       = 0;
        instr_valid = 0;
        opnd_ready  = 0;
        wb_valid    = 0;
        #1;
        chk("rst_ctrl", {RegRead, RegWrite, opnd_valid, wb_ready, instr_ready}, 0);
        chk("rst_opnd", {opnd_a, opnd_b}, 0);
        chk("rst_addr", {readRegA, readRegB, writeReg}, 0);
        chk("rst_wdata", writeData, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rel_ready", instr_ready, 1);
        chk("rel_no_wr", RegWrite, 0);
        prev_wr = 0;
    endtask

    // abort: 0 none, 1 reset while in OPND, 2 reset while in WR.
    task automatic run_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic dst_sel, input int unsigned hold,
                             input logic [31:0] wdata, input logic wen, input int unsigned abort);
        opnd_t       eo;
        wr_t         ew;
        logic [4:0]  dest;
        logic        exp_wr;
        int unsigned waited;
        dest        = dst_sel ? rd : rt;
        instr       = {6'h23, rs, rt, rd, 11'h5a5};
        reg_dst     = dst_sel;
        instr_valid = 1;
        waited      = 0;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_wait", waited, prev_wr ? 1 : 0);
        eo.a = exp_operand(rs);
        eo.b = exp_operand(rt);
        opnd_q.push_back(eo);
        @(negedge clk);
        instr_valid = 0;
        instr       = $urandom();
        reg_dst     = ~dst_sel;
        chk("rd_pulse", RegRead, 1);
        chk("rd_addr_a", readRegA, rs);
        chk("rd_addr_b", readRegB, rt);
        chk("rd_no_ready", instr_ready, 0);
        @(negedge clk);
        chk("cap_rd_off", RegRead, 0);
        chk("cap_no_valid", opnd_valid, 0);
        @(negedge clk);
        chk("lat_valid", opnd_valid, 1);
        eo = opnd_q.pop_front();
        chk("opnd_a", opnd_a, eo.a);
        chk("opnd_b", opnd_b, eo.b);
        if (abort == 1) begin
            #1;
            do_reset();
            return;
        end
        wb_valid = 1;
        wb_en    = 1;
        wb_data  = $urandom();
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", opnd_valid, 1);
            chk("hold_a", opnd_a, eo.a);
            chk("hold_b", opnd_b, eo.b);
            chk("hold_no_wb", wb_ready, 0);
        end
        opnd_ready = 1;
        @(negedge clk);
        opnd_ready = 0;
        chk("wb_ready", wb_ready, 1);
        chk("wb_no_valid", opnd_valid, 0);
        if (hold > 1) begin
            wb_valid = 0;
            @(negedge clk);
            chk("wb_wait", wb_ready, 1);
        end
        wb_valid = 1;
        wb_en    = wen;
        wb_data  = wdata;
        exp_wr   = wen && (dest != 5'd0);
        if (exp_wr && abort != 2) begin
            ew.a = dest;
            ew.d = wdata;
            wr_q.push_back(ew);
            n_exp_wr++;
        end
        if (exp_wr && abort == 2) begin
            @(posedge clk);
            #1;
            wb_valid = 0;
            chk("wr_pre_rst", RegWrite, 1);
            do_reset();
            return;
        end
        @(negedge clk);
        wb_valid = 0;
        wb_data  = $urandom();
        if (exp_wr) begin
            chk("wr_pulse", RegWrite, 1);
            exp_rf[dest] = wdata;
            prev_wr = 1;
        end else begin
            chk("no_wr", RegWrite, 0);
            chk("back_idle", instr_ready, 1);
            prev_wr = 0;
        end
    endtask

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        for (int i = 0; i < 32; i++) exp_rf[i] = init_val(i);
        rf_init = 1;
        @(negedge clk);
        @(negedge clk);
        rf_init = 0;
        do_reset();

        run_instr(5'd3, 5'd7, 5'd0, 1'b0, 0, 32'h0000_1234, 1'b0, 0);
        run_instr(5'd3, 5'd7, 5'd9, 1'b1, 0, 32'hDEAD_BEEF, 1'b1, 0);
        run_instr(5'd9, 5'd3, 5'd12, 1'b1, 2, 32'hCAFE_0001, 1'b1, 0);
        run_instr(5'd12, 5'd0, 5'd0, 1'b1, 0, 32'h0000_0077, 1'b1, 0);
        run_instr(5'd5, 5'd6, 5'd10, 1'b1, 5, 32'h0BAD_F00D, 1'b1, 0);
        run_instr(5'd0, 5'd10, 5'd0, 1'b0, 1, 32'h0000_0099, 1'b0, 0);
        run_instr(5'd1, 5'd2, 5'd3, 1'b1, 3, 32'h0000_0005, 1'b1, 1);
        run_instr(5'd4, 5'd3, 5'd3, 1'b1, 0, 32'hFFFF_0000, 1'b1, 2);
        run_instr(5'd3, 5'd4, 5'd14, 1'b1, 0, 32'h0000_0001, 1'b1, 0);

        for (int k = 0; k < 10; k++) begin
            run_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom(), 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge clk);
        chk("wrq_empty", wr_q.size(), 0);
        chk("wr_count", n_wr, n_exp_wr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
